// File: rtl/fsb_slave_regs.sv
// 68030 FSB responder for the accelerator control window: three R/W config
// registers plus a read-only ID register, terminated with 32-bit nDSACK or nBERR.
module fsb_slave_regs #(
    parameter logic [31:0] BASE_ADDR   = 32'h5000_0000,
    parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FFF0,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'h574C_4301
) (
    input  logic        FSBCLK,
    input  logic        nRESET,
    input  logic        CPU_nAS,
    input  logic        CPU_nDS,
    input  logic        CPU_RnW,
    input  logic [1:0]  CPU_SIZ,
    input  logic [31:0] FSB_A,
    input  logic [31:0] FSB_D_IN,
    output logic [31:0] FSB_D_OUT,
    output logic        FSB_D_OE,
    output logic [1:0]  CPU_nDSACK,
    output logic        CPU_nBERR,
    output logic        TERM_OE,
    output logic [95:0] CFG_OUT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IGNORE,
        S_WAIT,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_as;
    logic        r_ds;
    logic        r_rnw;
    logic [1:0]  r_siz;
    logic [31:0] r_a;
    logic [31:0] r_d;

    logic [3:0]  r_lat_a;
    logic        r_lat_rnw;
    logic [1:0]  r_lat_siz;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_latch;

    logic [31:0] r_reg0;
    logic [31:0] r_reg1;
    logic [31:0] r_reg2;

    logic [1:0]  r_dsack;
    logic        r_berr;
    logic        r_term_oe;
    logic        r_d_oe;
    logic [31:0] r_d_out;
    logic [1:0]  w_dsack_nxt;
    logic        w_berr_nxt;
    logic        w_term_oe_nxt;
    logic        w_d_oe_nxt;
    logic [31:0] w_d_out_nxt;

    logic        w_hit;
    logic [1:0]  w_sel;
    logic [31:0] w_cur;
    logic [31:0] w_rd_data;
    logic [3:0]  w_lane_en;
    logic [31:0] w_wr_data;
    logic        w_wr_en;

    // Bus inputs are registered once; the FSM never looks at the raw pins.
    always_ff @(posedge FSBCLK) begin
        if (!nRESET) begin
            r_as  <= 1'b1;
            r_ds  <= 1'b1;
            r_rnw <= 1'b1;
            r_siz <= '0;
            r_a   <= '0;
            r_d   <= '0;
        end else begin
            r_as  <= CPU_nAS;
            r_ds  <= CPU_nDS;
            r_rnw <= CPU_RnW;
            r_siz <= CPU_SIZ;
            r_a   <= FSB_A;
            r_d   <= FSB_D_IN;
        end
    end

    assign w_hit = (r_a & ADDR_MASK) == BASE_ADDR;
    assign w_sel = r_lat_a[3:2];

    always_comb begin
        w_cur     = '0;
        w_rd_data = ID_VALUE;
        case (w_sel)
            2'd0: begin
                w_cur     = r_reg0;
                w_rd_data = r_reg0;
            end
            2'd1: begin
                w_cur     = r_reg1;
                w_rd_data = r_reg1;
            end
            2'd2: begin
                w_cur     = r_reg2;
                w_rd_data = r_reg2;
            end
            default: begin
                w_cur     = '0;
                w_rd_data = ID_VALUE;
            end
        endcase
    end

    // Lane 0 is D31:24; lanes past the longword end are left for the CPU to re-run.
    always_comb begin
        w_lane_en = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_lane_en[i] = (i >= 32'(r_lat_a[1:0])) &&
                           (i < 32'(r_lat_a[1:0]) +
                                ((r_lat_siz == 2'b00) ? 32'd4 : 32'(r_lat_siz)));
        end
    end

    always_comb begin
        w_wr_data = w_cur;
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_lane_en[i]) begin
                w_wr_data[31 - 8*i -: 8] = r_d[31 - 8*i -: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_latch       = 1'b0;
        w_wr_en       = 1'b0;
        w_dsack_nxt   = r_dsack;
        w_berr_nxt    = r_berr;
        w_term_oe_nxt = r_term_oe;
        w_d_oe_nxt    = r_d_oe;
        w_d_out_nxt   = r_d_out;

        case (r_state)
            S_IDLE: begin
                w_dsack_nxt   = '1;
                w_berr_nxt    = 1'b1;
                w_term_oe_nxt = 1'b0;
                w_d_oe_nxt    = 1'b0;
                if (!r_as) begin
                    if (w_hit) begin
                        w_state_nxt   = S_WAIT;
                        w_latch       = 1'b1;
                        w_cnt_nxt     = 4'(WAIT_STATES);
                        w_term_oe_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_IGNORE;
                    end
                end
            end

            S_IGNORE: begin
                w_dsack_nxt   = '1;
                w_berr_nxt    = 1'b1;
                w_term_oe_nxt = 1'b0;
                w_d_oe_nxt    = 1'b0;
                if (r_as) begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_WAIT: begin
                if (r_as) begin
                    w_state_nxt   = S_IDLE;
                    w_term_oe_nxt = 1'b0;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else if (r_lat_rnw) begin
                    w_state_nxt = S_ACK;
                    w_d_out_nxt = w_rd_data;
                    w_d_oe_nxt  = 1'b1;
                    w_dsack_nxt = 2'b00;
                end else if (!r_ds) begin
                    w_state_nxt = S_ACK;
                    if (w_sel == 2'd3) begin
                        w_berr_nxt = 1'b0;
                    end else begin
                        w_wr_en     = 1'b1;
                        w_dsack_nxt = 2'b00;
                    end
                end
            end

            S_ACK: begin
                if (r_as) begin
                    w_state_nxt = S_RELEASE;
                    w_dsack_nxt = '1;
                    w_berr_nxt  = 1'b1;
                    w_d_oe_nxt  = 1'b0;
                end
            end

            S_RELEASE: begin
                w_state_nxt   = S_IDLE;
                w_term_oe_nxt = 1'b0;
            end

            default: begin
                w_state_nxt   = S_IDLE;
                w_dsack_nxt   = '1;
                w_berr_nxt    = 1'b1;
                w_term_oe_nxt = 1'b0;
                w_d_oe_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge FSBCLK) begin
        if (!nRESET) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_lat_a   <= '0;
            r_lat_rnw <= 1'b1;
            r_lat_siz <= '0;
            r_dsack   <= '1;
            r_berr    <= 1'b1;
            r_term_oe <= 1'b0;
            r_d_oe    <= 1'b0;
            r_d_out   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dsack   <= w_dsack_nxt;
            r_berr    <= w_berr_nxt;
            r_term_oe <= w_term_oe_nxt;
            r_d_oe    <= w_d_oe_nxt;
            r_d_out   <= w_d_out_nxt;
            if (w_latch) begin
                r_lat_a   <= r_a[3:0];
                r_lat_rnw <= r_rnw;
                r_lat_siz <= r_siz;
            end
        end
    end

    always_ff @(posedge FSBCLK) begin
        if (!nRESET) begin
            r_reg0 <= '0;
            r_reg1 <= '0;
            r_reg2 <= '0;
        end else if (w_wr_en) begin
            case (w_sel)
                2'd0:    r_reg0 <= w_wr_data;
                2'd1:    r_reg1 <= w_wr_data;
                2'd2:    r_reg2 <= w_wr_data;
                default: ;
            endcase
        end
    end

    assign FSB_D_OUT  = r_d_out;
    assign FSB_D_OE   = r_d_oe;
    assign CPU_nDSACK = r_dsack;
    assign CPU_nBERR  = r_berr;
    assign TERM_OE    = r_term_oe;
    assign CFG_OUT    = {r_reg2, r_reg1, r_reg0};

endmodule

// File: tb/tb_fsb_slave_regs.sv
// Scoreboard bench for fsb_slave_regs: a bus-cycle model pushes expected
// terminations, which are popped and compared when the DUT terminates.
module tb_fsb_slave_regs;

    localparam int unsigned WS  = 1;
    localparam int unsigned WS4 = 4;
    localparam logic [31:0] ID  = 32'h574C_4301;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        nres, nas, nas4, nds, rnw;
    logic [1:0]  siz;
    logic [31:0] a, din;

    logic [31:0] dout,  dout4;
    logic        doe,   doe4;
    logic [1:0]  dsack, dsack4;
    logic        berr,  berr4;
    logic        term,  term4;
    logic [95:0] cfg,   cfg4;

    fsb_slave_regs #(.WAIT_STATES(WS)) u_dut (
        .FSBCLK(clk), .nRESET(nres), .CPU_nAS(nas), .CPU_nDS(nds), .CPU_RnW(rnw),
        .CPU_SIZ(siz), .FSB_A(a), .FSB_D_IN(din), .FSB_D_OUT(dout), .FSB_D_OE(doe),
        .CPU_nDSACK(dsack), .CPU_nBERR(berr), .TERM_OE(term), .CFG_OUT(cfg)
    );

    // Second instance with a longer wait count, strobed by its own nAS.
    fsb_slave_regs #(.WAIT_STATES(WS4)) u_dut4 (
        .FSBCLK(clk), .nRESET(nres), .CPU_nAS(nas4), .CPU_nDS(nds), .CPU_RnW(rnw),
        .CPU_SIZ(siz), .FSB_A(a), .FSB_D_IN(din), .FSB_D_OUT(dout4), .FSB_D_OE(doe4),
        .CPU_nDSACK(dsack4), .CPU_nBERR(berr4), .TERM_OE(term4), .CFG_OUT(cfg4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [1:0]  dsack;
        logic        berr;
        logic        doe;
        logic        rd;
        logic [31:0] rdata;
        logic [95:0] cfg;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_reg[3];

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic push_exp(input logic [31:0] addr, input logic r, input logic [1:0] s,
                            input logic [31:0] wd, input int ds_delay);
        exp_t e;
        int   sel, off, n;
        sel = int'(addr[3:2]);
        off = int'(addr[1:0]);
        n   = (s == 2'b00) ? 4 : int'(s);
        e.rd    = r;
        e.rdata = '0;
        if (r) begin
            e.dsack = 2'b00; e.berr = 1'b1; e.doe = 1'b1;
            e.rdata = (sel == 3) ? ID : m_reg[sel];
        end else if (sel == 3) begin
            e.dsack = 2'b11; e.berr = 1'b0; e.doe = 1'b0;
        end else begin
            e.dsack = 2'b00; e.berr = 1'b1; e.doe = 1'b0;
            for (int b = off; b < off + n && b < 4; b++)
                m_reg[sel][31 - 8*b -: 8] = wd[31 - 8*b -: 8];
        end
        e.cfg = {m_reg[2], m_reg[1], m_reg[0]};
        e.lat = (int'(WS) + 3 > ds_delay + 2) ? int'(WS) + 3 : ds_delay + 2;
        sb.push_back(e);
    endtask

    task automatic bus_cycle(input string tag, input logic [31:0] addr, input logic r,
                             input logic [1:0] s, input logic [31:0] wd, input int ds_delay);
        exp_t e;
        int   lat;
        bit   got;
        push_exp(addr, r, s, wd, ds_delay);
        @(negedge clk);
        a = addr; rnw = r; siz = s; din = wd; nas = 1'b0;
        nds = (ds_delay == 0) ? 1'b0 : 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == ds_delay) nds = 1'b0;
            got = term && (dsack != 2'b11 || !berr);
        end
        e = sb.pop_front();
        chk({tag, ".term"}, 96'(got), 96'd1);
        chk({tag, ".lat"}, 96'(lat), 96'(e.lat));
        chk({tag, ".dsack"}, 96'(dsack), 96'(e.dsack));
        chk({tag, ".berr"}, 96'(berr), 96'(e.berr));
        chk({tag, ".doe"}, 96'(doe), 96'(e.doe));
        if (e.rd) chk({tag, ".rdata"}, 96'(dout), 96'(e.rdata));
        chk({tag, ".cfg"}, cfg, e.cfg);
        nas = 1'b1; nds = 1'b1;
        @(negedge clk);
        chk({tag, ".hold"}, 96'({dsack, berr, doe}), 96'({e.dsack, e.berr, e.doe}));
        @(negedge clk);
        chk({tag, ".release"}, 96'({term, dsack, berr, doe}), 96'(5'b1_11_1_0));
        @(negedge clk);
        chk({tag, ".idle"}, 96'(term), 96'd0);
    endtask

    task automatic miss_cycle(input string tag, input logic [31:0] addr);
        bit ok = 1'b1;
        @(negedge clk);
        a = addr; rnw = 1'b1; siz = 2'b00; nas = 1'b0; nds = 1'b0;
        repeat (6) begin
            @(negedge clk);
            ok &= !term && !doe;
        end
        nas = 1'b1; nds = 1'b1;
        repeat (3) begin
            @(negedge clk);
            ok &= !term && !doe;
        end
        chk({tag, ".quiet"}, 96'(ok), 96'd1);
    endtask

    initial begin
        bit ok;
        int lat;
        nres = 1'b0; nas = 1'b1; nas4 = 1'b1; nds = 1'b1; rnw = 1'b1;
        siz = '0; a = '0; din = '0;
        for (int i = 0; i < 3; i++) m_reg[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.outs", 96'({dsack, berr, term, doe}), 96'(5'b11_1_0_0));
        chk("rst.dout", 96'(dout), 96'd0);
        chk("rst.cfg", cfg, 96'd0);
        nres = 1'b1;

        bus_cycle("wr_long",   32'h5000_0004, 1'b0, 2'b00, 32'hDEAD_BEEF, 0);
        bus_cycle("wr_byte",   32'h5000_0006, 1'b0, 2'b01, 32'h0000_AB00, 0);
        bus_cycle("wr_r0",     32'h5000_0000, 1'b0, 2'b00, 32'h1122_3344, 0);
        bus_cycle("wr_word",   32'h5000_000A, 1'b0, 2'b10, 32'h0000_5566, 0);
        bus_cycle("wr_3b_end", 32'h5000_0003, 1'b0, 2'b11, 32'h0000_00AA, 0);
        bus_cycle("wr_3b_mid", 32'h5000_0009, 1'b0, 2'b11, 32'h99CC_DDEE, 0);
        bus_cycle("rd_id",     32'h5000_000C, 1'b1, 2'b00, 32'h0, 0);
        bus_cycle("rd_r1",     32'h5000_0004, 1'b1, 2'b00, 32'h0, 0);
        bus_cycle("rd_byte",   32'h5000_0001, 1'b1, 2'b01, 32'h0, 0);
        bus_cycle("wr_id",     32'h5000_000C, 1'b0, 2'b00, 32'h0BAD_0BAD, 0);
        miss_cycle("miss_hi", 32'h5000_0010);
        miss_cycle("miss_lo", 32'h4000_0004);
        bus_cycle("wr_lateds", 32'h5000_0008, 1'b0, 2'b00, 32'h0F0F_0F0F, 4);
        bus_cycle("rd_r2",     32'h5000_0008, 1'b1, 2'b00, 32'h0, 0);

        // Abort during WAIT on the long-wait instance.
        @(negedge clk);
        a = 32'h5000_0000; rnw = 1'b0; siz = 2'b00; din = 32'hCAFE_F00D;
        nas4 = 1'b0; nds = 1'b0;
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            ok &= (dsack4 == 2'b11) && berr4;
        end
        nas4 = 1'b1; nds = 1'b1;
        repeat (6) begin
            @(negedge clk);
            ok &= (dsack4 == 2'b11) && berr4;
        end
        chk("abort.noack", 96'(ok), 96'd1);
        chk("abort.idle", 96'(term4), 96'd0);
        chk("abort.cfg", cfg4, 96'd0);

        // Long-wait read: latency and that the aborted write left reg0 alone.
        @(negedge clk);
        a = 32'h5000_0000; rnw = 1'b1; nas4 = 1'b0; nds = 1'b0;
        lat = 0;
        ok = 1'b0;
        while (!ok && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            ok = term4 && (dsack4 != 2'b11);
        end
        chk("ws4.lat", 96'(lat), 96'(WS4 + 3));
        chk("ws4.rdata", 96'({doe4, dout4}), 96'({1'b1, 32'h0}));
        nas4 = 1'b1; nds = 1'b1;
        repeat (3) @(negedge clk);
        chk("ws4.idle", 96'(term4), 96'd0);

        // Reset in the middle of a write.
        @(negedge clk);
        a = 32'h5000_0004; rnw = 1'b0; siz = 2'b00; din = 32'h1234_5678;
        nas = 1'b0; nds = 1'b0;
        ok = 1'b1;
        repeat (2) begin
            @(negedge clk);
            ok &= (dsack == 2'b11) && berr;
        end
        nres = 1'b0; nas = 1'b1; nds = 1'b1;
        @(negedge clk);
        nres = 1'b1;
        for (int i = 0; i < 3; i++) m_reg[i] = '0;
        repeat (3) begin
            @(negedge clk);
            ok &= (dsack == 2'b11) && berr && !term;
        end
        chk("rstmid.noack", 96'(ok), 96'd1);
        chk("rstmid.cfg", cfg, 96'd0);

        bus_cycle("wr_after", 32'h5000_0004, 1'b0, 2'b00, 32'hA5A5_5A5A, 0);
        bus_cycle("rd_after", 32'h5000_0004, 1'b1, 2'b00, 32'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
